serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder wrapping the team's combinational `full_adder` cell with operand shift registers, a carry flip-flop and a start/done handshake. It adds two `WIDTH`-bit operands LSB-first, one bit per clock, producing a `WIDTH`-bit sum and a carry-out. It sits directly upstream of a single `full_adder` instance, feeding it one bit pair plus the registered carry each cycle and consuming its `S`/`Co`. It trades latency for area where a ripple array of `WIDTH` adders is too large.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width; legal range is `WIDTH >= 2`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request to begin an addition; sampled only in IDLE or DONE.
- `A` input `WIDTH`: operand A; captured on an accepted `start`.
- `B` input `WIDTH`: operand B; captured on an accepted `start`.
- `Ci` input 1: carry-in; captured on an accepted `start`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; `S`/`Co` valid from this cycle onward.
- `S` output `WIDTH`: registered sum; holds its value until the next `done`.
- `Co` output 1: registered carry-out; holds its value until the next `done`.

## Operation
- **Reset:** state IDLE; `busy`=0, `done`=0, `S`=0, `Co`=0; shift registers, carry flip-flop and bit counter all cleared.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 → load `a_sr`←`A`, `b_sr`←`B`, `carry`←`Ci`, `cnt`←0; go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** one bit per cycle.
  - The `full_adder` inputs are `a_sr[0]`, `b_sr[0]` and `carry`.
  - `carry`←`Co` of the cell.
  - `a_sr` and `b_sr` shift right with zero fill.
  - `s_sr` shifts right with the cell's `S` entering at bit `WIDTH-1`.
  - `cnt` increments each cycle.
  - When `cnt`==`WIDTH-1`, that bit is still processed, the final sum and carry are copied to `S`/`Co`, and the state goes to DONE.
- **DONE:** `done`=1 for exactly this cycle.
  - `start`=1 → reload exactly as from IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- **`start` during RUN** is ignored. No queueing; operands are not re-sampled.
- **`A`, `B`, `Ci`** may change freely after the accept cycle without affecting the sum in progress.
- **Arithmetic:** {`Co`,`S`} = `A` + `B` + `Ci`, modulo 2^(`WIDTH`+1), with no truncation. The maximum is 2^(`WIDTH`+1)−1.
- **Reset mid-RUN** aborts the operation: no `done` pulse, and `S`/`Co` read 0.
- **Output stability:** `S`/`Co` do not change during RUN; they update only on entry to DONE.

## Timing
- `start` sampled high at edge *t* → `busy`=1 in cycles *t*+1 … *t*+`WIDTH`.
- `done`=1 and new `S`/`Co` are visible in cycle *t*+`WIDTH`+1. Latency is `WIDTH`+1 cycles.
- Back-to-back throughput: one result every `WIDTH`+1 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `serial_adder_pkg`:
  - State typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter-width constant `CNT_W` = $clog2(`WIDTH`).
- Exactly one `full_adder` instance, used as the per-bit datapath.
- No other sub-modules.
- The FSM, counter and shift registers live in `serial_adder`.

## Test plan
- **Basic add:** `WIDTH`=8, `A`=0x5A, `B`=0x3C, `Ci`=0, `start` at edge *t* → `done` at *t*+9, `S`=0x96, `Co`=0, `busy` high for exactly 8 cycles.
- **Overflow:** `A`=0xFF, `B`=0x01, `Ci`=0 → `S`=0x00, `Co`=1. Then `A`=0xFF, `B`=0x00, `Ci`=1 → `S`=0x00, `Co`=1, confirming the carry ripples through all 8 bits.
- **Busy-ignore:** start 0x10+0x20. At *t*+3, pulse `start` with `A`=0xFF, `B`=0xFF → single `done` at *t*+9 with `S`=0x30, `Co`=0. No second `done`.
- **Back-to-back:** assert `start` with 0x01+0x01 in the `done` cycle of a prior op → next `done` 9 cycles later with `S`=0x02. Prior `S` is held until then.
- **Reset mid-RUN:** `rst` at *t*+4 of an active op → next cycle shows `busy`=0, `S`=0, `Co`=0, and no `done` appears. A fresh `start` afterwards completes normally.
- **Randomised sweep:** 1000 random (`A`, `B`, `Ci`) at `WIDTH`=8 and `WIDTH`=2 → {`Co`,`S`} matches `A`+`B`+`Ci` every time.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

   // FSM state encoding, kept as plain constants for legacy tools
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Bit-counter width for a given operand width: CNT_W = $clog2(WIDTH)
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational one-bit full adder cell, the per-bit datapath of serial_adder.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic S,
   output logic Co
);

   logic w_p;

   // Propagate term shared by sum and carry
   assign w_p = A ^ B;
   assign S   = w_p ^ Ci;
   assign Co  = (A & B) | (Ci & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full_adder.
// {Co,S} = A + B + Ci after WIDTH+1 cycles, with a start/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Co
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   // Sum shift register; its bit 0 is never stored because the bit that
   // would land there only ever feeds the final copy into S.
   logic [WIDTH-1:1] r_s_sr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_S;
   logic             r_Co;

   logic             w_sum;
   logic             w_cout;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_s_next;

   // start only counts when the engine is idle or just finishing
   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
   assign w_s_next = {w_sum, r_s_sr};

   full_adder u_fa (
      .A  (r_a_sr[0]),
      .B  (r_b_sr[0]),
      .Ci (r_carry),
      .S  (w_sum),
      .Co (w_cout)
   );

   // Control FSM: IDLE -> RUN for WIDTH cycles -> DONE for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start)  r_state <= ST_RUN;
            ST_RUN:  if (w_last) r_state <= ST_DONE;
            ST_DONE: r_state <= start ? ST_RUN : ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Operand capture and per-bit shifting; operands are frozen once accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_s_sr  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a_sr  <= A;
         r_b_sr  <= B;
         r_carry <= Ci;
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
         r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
         r_s_sr  <= w_s_next[WIDTH-1:1];
         r_carry <= w_cout;
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Result registers update only on the last bit, so they hold through RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_S  <= '0;
         r_Co <= 1'b0;
      end else if (w_last) begin
         r_S  <= w_s_next;
         r_Co <= w_cout;
      end
   end

   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);
   assign S    = r_S;
   assign Co   = r_Co;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       ci = 1'b0;
   logic       busy, done, co;
   logic [7:0] s;

   logic       start2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       ci2 = 1'b0;
   logic       busy2, done2, co2;
   logic [1:0] s2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Ci(ci),
      .busy(busy), .done(done), .S(s), .Co(co)
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2), .Ci(ci2),
      .busy(busy2), .done(done2), .S(s2), .Co(co2)
   );

   // Launch one WIDTH=8 op; return in the done cycle (lat=0 on timeout)
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       output int lat, output int nbusy, output logic overlap);
      @(negedge clk);
      a = ia; b = ib; ci = ic; start = 1'b1;
      lat = 0; nbusy = 0; overlap = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) nbusy++;
         if (busy && done) overlap = 1'b1;
         if (done) begin lat = k; break; end
      end
   endtask

   task automatic run2(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                       output int lat);
      @(negedge clk);
      a2 = ia; b2 = ib; ci2 = ic; start2 = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) begin lat = k; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h expected 00", s); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b expected 0", co); end
      checks++; if ({busy2, done2, s2, co2} !== 5'b0) begin errors++; $display("FAIL reset_w2: got %b expected 00000", {busy2, done2, s2, co2}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, nb; logic ov;
      run8(8'h5A, 8'h3C, 1'b0, lat, nb, ov);
      checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency: got %0d expected 9", lat); end
      checks++; if (nb != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", nb); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL basic_busy_done_overlap: got %b expected 0", ov); end
      checks++; if (s !== 8'h96) begin errors++; $display("FAIL basic_sum: got %h expected 96", s); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_co: got %b expected 0", co); end
   endtask

   task automatic test_overflow();
      int lat, nb; logic ov;
      run8(8'hFF, 8'h01, 1'b0, lat, nb, ov);
      checks++; if ({co, s} !== 9'h100 || lat != 9) begin errors++; $display("FAIL ovf_ff_01: got %h lat %0d expected 100 lat 9", {co, s}, lat); end
      run8(8'hFF, 8'h00, 1'b1, lat, nb, ov);
      checks++; if ({co, s} !== 9'h100 || lat != 9) begin errors++; $display("FAIL ovf_ff_ci: got %h lat %0d expected 100 lat 9", {co, s}, lat); end
   endtask

   // Prior result is {Co,S}=100; a start mid-RUN must not disturb anything
   task automatic test_busy_ignore();
      int done_k = 0, ndone = 0;
      logic [8:0] res = '0;
      logic held_bad = 1'b0;
      @(negedge clk);
      a = 8'h10; b = 8'h20; ci = 1'b0; start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
         if (!done && ndone == 0 && {co, s} !== 9'h100) held_bad = 1'b1;
         if (done) begin
            ndone++;
            if (done_k == 0) begin done_k = k; res = {co, s}; end
         end
      end
      checks++; if (done_k != 9) begin errors++; $display("FAIL ignore_latency: got %0d expected 9", done_k); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
      checks++; if (res !== 9'h030) begin errors++; $display("FAIL ignore_sum: got %h expected 030", res); end
      checks++; if (held_bad !== 1'b0) begin errors++; $display("FAIL ignore_held: got %b expected 0", held_bad); end
   endtask

   task automatic test_back_to_back();
      int lat, nb; logic ov;
      int lat2 = 0;
      logic held_bad = 1'b0;
      run8(8'h33, 8'h44, 1'b0, lat, nb, ov);
      checks++; if (s !== 8'h77 || lat != 9) begin errors++; $display("FAIL b2b_first: got %h lat %0d expected 77 lat 9", s, lat); end
      // Still inside the done cycle: issue the next start now
      a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (!done && s !== 8'h77) held_bad = 1'b1;
         if (done) begin lat2 = k; break; end
      end
      checks++; if (lat2 != 9) begin errors++; $display("FAIL b2b_latency: got %0d expected 9", lat2); end
      checks++; if (held_bad !== 1'b0) begin errors++; $display("FAIL b2b_held: got %b expected 0", held_bad); end
      checks++; if ({co, s} !== 9'h002) begin errors++; $display("FAIL b2b_sum: got %h expected 002", {co, s}); end
   endtask

   task automatic test_reset_mid();
      int ndone = 0, lat, nb; logic ov;
      @(negedge clk);
      a = 8'h80; b = 8'h80; ci = 1'b1; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({busy, done, co, s} !== 11'b0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 000", {busy, done, co, s}); end
      rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", ndone); end
      run8(8'h0F, 8'h01, 1'b1, lat, nb, ov);
      checks++; if ({co, s} !== 9'h011 || lat != 9) begin errors++; $display("FAIL rstmid_fresh: got %h lat %0d expected 011 lat 9", {co, s}, lat); end
   endtask

   task automatic test_random();
      int lat, nb; logic ov;
      logic [7:0] ra, rb; logic rc; logic [8:0] exp8;
      logic [1:0] qa, qb; logic qc; logic [2:0] exp2;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rc = 1'($urandom_range(0, 1));
         exp8 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         run8(ra, rb, rc, lat, nb, ov);
         checks++;
         if ({co, s} !== exp8 || lat != 9) begin
            errors++; $display("FAIL rand8 %h+%h+%b: got %h lat %0d expected %h lat 9", ra, rb, rc, {co, s}, lat, exp8);
         end
      end
      for (int i = 0; i < 1000; i++) begin
         qa = 2'($urandom_range(0, 3)); qb = 2'($urandom_range(0, 3)); qc = 1'($urandom_range(0, 1));
         exp2 = {1'b0, qa} + {1'b0, qb} + {2'b0, qc};
         run2(qa, qb, qc, lat);
         checks++;
         if ({co2, s2} !== exp2 || lat != 3) begin
            errors++; $display("FAIL rand2 %h+%h+%b: got %h lat %0d expected %h lat 3", qa, qb, qc, {co2, s2}, lat, exp2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
